// File: rtl/bus_pkg.sv
// Shared constants and address helpers for the MCU bus register bank.
package bus_pkg;

  localparam int unsigned BusAw     = 12;
  localparam int unsigned BusDw     = 16;
  localparam int unsigned BusSelLsb = 8;

  // Channel-select field of a zero-extended address: everything above sel_lsb.
  function automatic int unsigned sel_of(input logic [31:0] addr, input int unsigned sel_lsb);
    return addr >> sel_lsb;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous strobe with registered edge outputs.
// History resets to 1 so a strobe already high at reset release never counts as an edge.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Shift the strobe through the chain and register edge flags; lvl_o is aligned with them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign lvl_o  = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/bus_regbank.sv
// MCU parallel-bus register bank: synchronised strobes, per-channel write registers,
// latched readback on a tri-state data bus, sticky error for unmapped/conflicting access.
module bus_regbank
  import bus_pkg::*;
#(
  parameter int unsigned AW          = BusAw,
  parameter int unsigned DW          = BusDw,
  parameter int unsigned NCH         = 4,
  parameter int unsigned SEL_LSB     = BusSelLsb,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     addr,
  input  logic              rd,
  input  logic              wr,
  inout  wire  [DW-1:0]     data,
  input  logic [NCH*DW-1:0] rddat,
  output logic [NCH*DW-1:0] otdata,
  output logic [NCH-1:0]    wr_stb,
  output logic [NCH-1:0]    rd_stb,
  output logic [NCH-1:0]    cs,
  input  logic              err_clr,
  output logic              bus_err
);

  logic [SYNC_STAGES-1:0][AW-1:0] addr_q;
  logic [SYNC_STAGES-1:0][DW-1:0] data_q;
  logic [AW-1:0]                  addr_s;
  logic [DW-1:0]                  data_s;

  logic rd_lvl, rd_rise, rd_fall;
  logic wr_lvl, wr_rise, wr_fall;

  logic [NCH*DW-1:0] otdata_q, otdata_d;
  logic [NCH-1:0]    wr_stb_q, wr_stb_d;
  logic [NCH-1:0]    rd_stb_q, rd_stb_d;
  logic [NCH-1:0]    cs_q, cs_d;
  logic [DW-1:0]     rdlatch_q, rdlatch_d;
  logic              drive_en_q, drive_en_d;
  logic              bus_err_q, bus_err_d;

  int unsigned       sel;
  logic [NCH-1:0]    sel_oh;
  logic [DW-1:0]     rd_word;
  logic              mapped;
  logic              wr_go, rd_go, conflict, err_set;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rd),
    .lvl_o (rd_lvl),
    .rise_o(rd_rise),
    .fall_o(rd_fall)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_wr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (wr),
    .lvl_o (wr_lvl),
    .rise_o(wr_rise),
    .fall_o(wr_fall)
  );

  // Plain flop chains for address and data, same depth as the strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= {addr_q[SYNC_STAGES-2:0], addr};
      data_q <= {data_q[SYNC_STAGES-2:0], data};
    end
  end

  assign addr_s = addr_q[SYNC_STAGES-1];
  assign data_s = data_q[SYNC_STAGES-1];
  assign sel    = sel_of(32'(addr_s), SEL_LSB);

  // One-hot channel decode and readback mux; all-zero when sel is out of range.
  always_comb begin
    sel_oh  = '0;
    rd_word = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (sel == k) begin
        sel_oh[k] = 1'b1;
        rd_word   = rddat[k*DW +: DW];
      end
    end
  end

  assign mapped   = |sel_oh;
  assign wr_go    = wr_rise & ~rd_lvl;
  assign rd_go    = rd_rise & ~wr_lvl;
  assign conflict = (wr_rise | rd_rise) & rd_lvl & wr_lvl;
  assign err_set  = conflict | ((wr_go | rd_go) & ~mapped);

  // Next-state for write registers, strobes, read latch, bus drive and error flag.
  always_comb begin
    otdata_d   = otdata_q;
    wr_stb_d   = '0;
    rd_stb_d   = '0;
    cs_d       = sel_oh;
    rdlatch_d  = rdlatch_q;
    drive_en_d = drive_en_q;
    bus_err_d  = bus_err_q;

    if (wr_go) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (sel_oh[k]) begin
          otdata_d[k*DW +: DW] = data_s;
        end
      end
      wr_stb_d = sel_oh;
    end

    if (rd_go) begin
      rdlatch_d  = rd_word;
      rd_stb_d   = sel_oh;
      drive_en_d = 1'b1;
    end else if (rd_fall) begin
      drive_en_d = 1'b0;
    end

    // A new error in the same cycle as err_clr wins.
    if (err_set) begin
      bus_err_d = 1'b1;
    end else if (err_clr) begin
      bus_err_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      otdata_q   <= '0;
      wr_stb_q   <= '0;
      rd_stb_q   <= '0;
      cs_q       <= '0;
      rdlatch_q  <= '0;
      drive_en_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      otdata_q   <= otdata_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      cs_q       <= cs_d;
      rdlatch_q  <= rdlatch_d;
      drive_en_q <= drive_en_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign data    = drive_en_q ? rdlatch_q : {DW{1'bz}};
  assign otdata  = otdata_q;
  assign wr_stb  = wr_stb_q;
  assign rd_stb  = rd_stb_q;
  assign cs      = cs_q;
  assign bus_err = bus_err_q;

  // Write falling edge carries no action; kept for symmetry with the read path.
  logic unused_wr_fall;
  assign unused_wr_fall = wr_fall;

endmodule
